// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, IF/ID pipeline register and a RUN/HALTED FSM.
// Latency: one cycle from inst_in to IF/ID. A stall holds all state; a redirect overrides the stall and flushes IF/ID.
module fetch_stage #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic [6:0]  HALT_OPCODE = 7'h7F,
   parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   input  logic [31:0] inst_in,
   output logic [31:0] pc,
   output logic        if_id_valid,
   output logic [31:0] if_id_inst,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc_plus4,
   output logic        halted,
   output logic [31:0] fetch_count
);

   typedef enum logic {ST_RUN, ST_HALTED} state_t;

   state_t      state;
   state_t      next_state;
   logic        accept;
   logic        take_redirect;
   logic        clear_if_id;
   logic        is_halt;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc + 32'd4;
   assign halted   = (state == ST_HALTED);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_RUN;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state    = state;
      accept        = 1'b0;
      take_redirect = 1'b0;
      clear_if_id   = 1'b0;
      is_halt       = 1'b0;
      case (state)
         ST_RUN: begin
            if (redirect_valid) begin
               take_redirect = 1'b1;
               clear_if_id   = 1'b1;
            end else if (!stall) begin
               accept = 1'b1;
               if (inst_in[6:0] == HALT_OPCODE) begin
                  is_halt    = 1'b1;
                  next_state = ST_HALTED;
               end
            end
         end
         // The halt instruction stays visible for its one cycle in IF/ID, then bubbles follow.
         ST_HALTED: begin
            clear_if_id = 1'b1;
         end
         default: begin
            next_state = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc             <= RESET_PC;
         if_id_valid    <= 1'b0;
         if_id_inst     <= NOP_INST;
         if_id_pc       <= 32'd0;
         if_id_pc_plus4 <= 32'd0;
         fetch_count    <= 32'd0;
      end else begin
         if (take_redirect) begin
            pc <= {redirect_target[31:2], 2'b00};
         end else if (accept && !is_halt) begin
            pc <= pc_plus4;
         end

         if (clear_if_id) begin
            if_id_valid <= 1'b0;
            if_id_inst  <= NOP_INST;
         end else if (accept) begin
            if_id_valid    <= 1'b1;
            if_id_inst     <= inst_in;
            if_id_pc       <= pc;
            if_id_pc_plus4 <= pc_plus4;
         end

         if (accept) begin
            fetch_count <= fetch_count + 32'd1;
         end
      end
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 The block SHALL have parameter HALT_OPCODE, default 7'h7F, meaning the opcode field value that marks a halt instruction.
REQ-003 The block SHALL have parameter NOP_INST, default 32'h0000_0013, meaning the instruction word placed in IF/ID on bubble or flush.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 stall  input  1  hold PC and IF/ID this cycle.
REQ-007 redirect_valid  input  1  branch/jump taken; load redirect_target.
REQ-008 redirect_target  input  32  byte address of next instruction.
REQ-009 inst_in  input  32  instruction word returned combinationally by instruction memory for current pc.
REQ-010 pc  output  32  current fetch address, drives instruction memory.
REQ-011 if_id_valid  output  1  IF/ID register holds a real instruction.
REQ-012 if_id_inst  output  32  registered instruction word.
REQ-013 if_id_pc  output  32  address of if_id_inst.
REQ-014 if_id_pc_plus4  output  32  if_id_pc + 4, modulo 2^32.
REQ-015 halted  output  1  fetch stopped after a halt instruction.
REQ-016 fetch_count  output  32  number of instructions delivered with if_id_valid=1 since reset.

Function
REQ-017 The block SHALL implement a two-state FSM: RUN, HALTED; reset state RUN.
REQ-018 A fetch SHALL be "accepted" in a cycle when state=RUN, stall=0, redirect_valid=0.
REQ-019 On accept, pc SHALL become pc+4 (wrapping modulo 2^32), and IF/ID SHALL latch inst_in, pc, pc+4 with if_id_valid=1, one-cycle latency.
REQ-020 On redirect_valid=1 in RUN, pc SHALL become {redirect_target[31:2],2'b00}, and IF/ID SHALL flush: if_id_valid=0, if_id_inst=NOP_INST; redirect SHALL take priority over stall.
REQ-021 On stall=1 with redirect_valid=0, pc and all IF/ID outputs SHALL hold their values.
REQ-022 On accept with inst_in[6:0]=HALT_OPCODE, the halt instruction SHALL be latched into IF/ID as valid, pc SHALL hold (not advance), and state SHALL go to HALTED next cycle.
REQ-023 A halt opcode presented during stall or redirect SHALL NOT be latched and SHALL NOT cause a transition.
REQ-024 In HALTED, pc SHALL hold, halted SHALL be 1, and IF/ID SHALL hold its last contents for one cycle after entry, then read if_id_valid=0, if_id_inst=NOP_INST on every subsequent cycle.
REQ-025 HALTED SHALL be exited only by rst; stall and redirect_valid SHALL be ignored in HALTED.
REQ-026 fetch_count SHALL increment by 1 on every accept (including the halt instruction), wrapping from 32'hFFFF_FFFF to 0.
REQ-027 halted SHALL be a registered output equal to (state==HALTED).

Reset
REQ-028 While rst=1 at a clock edge, the block SHALL load: pc=RESET_PC, state=RUN, halted=0, if_id_valid=0, if_id_inst=NOP_INST, if_id_pc=0, if_id_pc_plus4=0, fetch_count=0.
REQ-029 rst SHALL take priority over stall, redirect_valid and halt detection, including mid-operation and in HALTED.
REQ-030 In the first cycle after rst deasserts, pc SHALL equal RESET_PC and the instruction at RESET_PC SHALL be accepted unless stall or redirect is asserted.

Verification
REQ-031 Sequential fetch: memory at 0x0,0x4,0x8 = 32'h00800293, 32'h00f00313, 32'h0062a023, no stall -> pc 0,4,8,C on successive cycles; if_id_inst follows one cycle later with if_id_pc 0,4,8; fetch_count 1,2,3.
REQ-032 Stall: assert stall for 2 cycles with pc=8 -> pc stays 8, IF/ID holds pc 4 instruction, fetch_count unchanged; after release pc=C.
REQ-033 Redirect+stall same cycle: redirect_target=32'h0000_0031, stall=1 -> next pc=32'h0000_0030, if_id_valid=0, if_id_inst=32'h00000013.
REQ-034 Halt: word 32'h0000007F at 0x30 -> IF/ID holds it valid with if_id_pc=0x30, pc stays 0x30, halted=1 next cycle, then if_id_valid=0; redirect to 0x0 ignored.
REQ-035 Wrap: RESET_PC=32'hFFFF_FFFC -> after one accept pc=0, if_id_pc_plus4=0.
REQ-036 Reset in HALTED: rst for one cycle -> pc=RESET_PC, halted=0, fetch_count=0, fetch resumes next cycle.
